tc_pl_cap_data_acprx: RTL and testbench

Read-back engine for captured data. On command it fetches a block of 64-bit beats from system memory over the ACP read channel, packs beat pairs into 128-bit words, and pushes them into the downstream capture buffer. It runs a CRC-32 over every beat so software can compare the result against the CRC produced when the data was written. It sits between the ACP read port and the read-side capture FIFO.

---
 rtl/tc_pl_cap_data_acprx.sv | 130 +++++++++++++
 tb/tb_tc_pl_cap_data_acprx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_pl_cap_data_acprx.sv
// Purpose: ACP read-back engine; fetches 4-beat bursts, packs beat pairs into 128-bit buffer words, runs CRC-32 per beat.
// Latency: buff_wr/buff_din one cycle after the odd beat; cap_crc32 one cycle after each beat; racp_cmpt one cycle after DONE.
// Backpressure: buff_prog_full gates only the next burst request (checked in WAIT); acp0_rx_en held until acp0_rx_rdy.
module tc_pl_cap_data_acprx #(
    parameter int          CAP0_7  = 32,
    parameter int          CAP0_8  = 32,
    parameter int          CAP0_15 = 128,
    parameter int          LEN_W   = 16,
    parameter logic [2:0]  ARID    = 3'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               racp_en,
    output logic               racp_cmpt,
    input  logic [CAP0_7-1:0]  cap_addr,
    input  logic [LEN_W-1:0]   cap_len,
    input  logic               cap_crc_en,
    output logic [CAP0_8-1:0]  cap_crc32,
    input  logic               buff_prog_full,
    output logic [CAP0_15-1:0] buff_din,
    output logic               buff_wr,
    output logic               acp0_rx_en,
    input  logic               acp0_rx_rdy,
    output logic [31:0]        acp0_rx_araddr,
    output logic [2:0]         acp0_rx_arid,
    input  logic [63:0]        acp0_rx_rdata,
    input  logic               acp0_rx_rdvld
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    logic [2:0]         state_q, state_d;
    logic [CAP0_7-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [1:0]         beat_q, beat_d;
    logic               cmpt_q;
    logic               wr_q;
    logic [CAP0_15-1:0] din_q;
    logic [CAP0_8-1:0]  crc_q;
    logic               beat_acc;

    // Whole 64-bit beat folded into the CRC in one cycle, bit 63 first.
    function automatic logic [31:0] crc32_beat(input logic [31:0] crc, input logic [63:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 63; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC_POLY : 32'd0);
        end
        return c;
    endfunction

    assign beat_acc = (state_q == S_DATA) && acp0_rx_rdvld;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (racp_en) begin
                    addr_d  = cap_addr;
                    rem_d   = cap_len;
                    state_d = (cap_len == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!buff_prog_full) state_d = S_REQ;
            end
            S_REQ: begin
                if (acp0_rx_rdy) begin
                    addr_d  = addr_q + CAP0_7'(32);
                    rem_d   = rem_q - LEN_W'(1);
                    beat_d  = 2'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (acp0_rx_rdvld) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = (rem_q != '0) ? S_WAIT : S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            cmpt_q  <= 1'b0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            crc_q   <= '1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            cmpt_q  <= (state_q == S_DONE);
            wr_q    <= beat_acc && beat_q[0];
            // Even beat parks in the low half; the odd beat completes the word.
            if (beat_acc) begin
                if (!beat_q[0]) din_q[CAP0_15/2-1:0]       <= acp0_rx_rdata;
                else            din_q[CAP0_15-1:CAP0_15/2] <= acp0_rx_rdata;
            end
            if (!cap_crc_en)   crc_q <= '1;
            else if (beat_acc) crc_q <= crc32_beat(crc_q, acp0_rx_rdata);
        end
    end

    assign racp_cmpt      = cmpt_q;
    assign buff_wr        = wr_q;
    assign buff_din       = din_q;
    assign cap_crc32      = crc_q;
    assign acp0_rx_en     = (state_q == S_REQ);
    assign acp0_rx_araddr = 32'(addr_q);
    assign acp0_rx_arid   = ARID;

endmodule

// File: tb/tb_tc_pl_cap_data_acprx.sv
// Directed bench for tc_pl_cap_data_acprx: table of transfers plus hand sequences for
// zero-length timing, all-zero CRC, and asynchronous reset in the middle of a burst.
`timescale 1ns/1ps
module tb_tc_pl_cap_data_acprx;

    logic         clk = 1'b0;
    logic         rst;
    logic         racp_en;
    logic         racp_cmpt;
    logic [31:0]  cap_addr;
    logic [15:0]  cap_len;
    logic         cap_crc_en;
    logic [31:0]  cap_crc32;
    logic         buff_prog_full;
    logic [127:0] buff_din;
    logic         buff_wr;
    logic         acp0_rx_en;
    logic         acp0_rx_rdy;
    logic [31:0]  acp0_rx_araddr;
    logic [2:0]   acp0_rx_arid;
    logic [63:0]  acp0_rx_rdata;
    logic         acp0_rx_rdvld;

    // Memory responder vs. manual drive of the read channel
    logic         resp_on, zero_data;
    logic         r_rdy, r_vld, m_rdy, m_vld;
    logic [63:0]  r_dat, m_dat;
    int           rdy_dly;

    assign acp0_rx_rdy   = resp_on ? r_rdy : m_rdy;
    assign acp0_rx_rdvld = resp_on ? r_vld : m_vld;
    assign acp0_rx_rdata = resp_on ? r_dat : m_dat;

    int checks = 0;
    int errors = 0;
    int wr_cnt, req_cnt, en_cycles, en_full, cmpt_cnt;
    logic [31:0] addr_log [8];

    typedef struct {
        logic [31:0]      addr;
        logic [15:0]      len;
        int               rdy_dly;
        int               pf_cycles;
        int               exp_wr;
        int               exp_req;
        logic [2:0][31:0] exp_a;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    tc_pl_cap_data_acprx dut (
        .clk            (clk),
        .rst            (rst),
        .racp_en        (racp_en),
        .racp_cmpt      (racp_cmpt),
        .cap_addr       (cap_addr),
        .cap_len        (cap_len),
        .cap_crc_en     (cap_crc_en),
        .cap_crc32      (cap_crc32),
        .buff_prog_full (buff_prog_full),
        .buff_din       (buff_din),
        .buff_wr        (buff_wr),
        .acp0_rx_en     (acp0_rx_en),
        .acp0_rx_rdy    (acp0_rx_rdy),
        .acp0_rx_araddr (acp0_rx_araddr),
        .acp0_rx_arid   (acp0_rx_arid),
        .acp0_rx_rdata  (acp0_rx_rdata),
        .acp0_rx_rdvld  (acp0_rx_rdvld)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Reference CRC over the beats 1..n (or n zero beats), bit-serial, MSB first.
    function automatic logic [31:0] crc_model(input int nbeats, input logic zeros);
        logic [31:0] c;
        logic [63:0] d;
        c = 32'hFFFFFFFF;
        for (int b = 0; b < nbeats; b++) begin
            d = zeros ? 64'd0 : 64'(b + 1);
            for (int i = 63; i >= 0; i--) begin
                if (c[31] ^ d[i]) c = (c << 1) ^ 32'h04C11DB7;
                else              c = c << 1;
            end
        end
        return c;
    endfunction

    // Responder: rdy after rdy_dly extra cycles, then 4 back-to-back beats.
    initial begin
        logic [63:0] beat_val;
        r_rdy = 1'b0; r_vld = 1'b0; r_dat = '0; beat_val = 64'd1;
        forever begin
            @(negedge clk);
            if (racp_en) beat_val = 64'd1;
            if (resp_on && acp0_rx_en) begin
                repeat (rdy_dly) @(negedge clk);
                r_rdy = 1'b1;
                @(negedge clk);
                r_rdy = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    r_dat = zero_data ? 64'd0 : beat_val;
                    beat_val++;
                    r_vld = 1'b1;
                    @(negedge clk);
                end
                r_vld = 1'b0;
            end
        end
    end

    // Monitor: write data/spacing, request addresses, address hold, completion pulses.
    initial begin
        logic        prev_wr, prev_en;
        logic [31:0] prev_a;
        prev_wr = 1'b0; prev_en = 1'b0; prev_a = '0;
        wr_cnt = 0; req_cnt = 0; en_cycles = 0; en_full = 0; cmpt_cnt = 0;
        forever begin
            @(negedge clk);
            if (racp_en) begin
                wr_cnt = 0; req_cnt = 0; en_cycles = 0; en_full = 0; cmpt_cnt = 0;
            end
            if (rst) begin
                if (buff_wr) begin
                    chk("wr_gap", 128'(prev_wr), 128'd0);
                    chk("wr_data", buff_din,
                        zero_data ? 128'd0 : {64'(2 * wr_cnt + 2), 64'(2 * wr_cnt + 1)});
                    wr_cnt++;
                end
                if (acp0_rx_en) begin
                    en_cycles++;
                    if (buff_prog_full) en_full++;
                    if (prev_en) chk("araddr_hold", 128'(acp0_rx_araddr), 128'(prev_a));
                    else begin
                        if (req_cnt < 8) addr_log[req_cnt] = acp0_rx_araddr;
                        req_cnt++;
                    end
                end
                if (racp_cmpt) cmpt_cnt++;
            end
            prev_wr = buff_wr; prev_en = acp0_rx_en; prev_a = acp0_rx_araddr;
        end
    end

    // Called at negedge+1; runs one transfer and checks its totals, CRC and CRC clear.
    task automatic run_vec(input vec_t v);
        int cyc, pf_left;
        rdy_dly  = v.rdy_dly;
        cap_addr = v.addr;
        cap_len  = v.len;
        racp_en  = 1'b1;
        @(negedge clk); #1;
        racp_en  = 1'b0;
        cyc = 0; pf_left = -1;
        while (cmpt_cnt == 0 && cyc < 3000) begin
            @(negedge clk); #1;
            cyc++;
            if (v.pf_cycles > 0 && pf_left < 0 && wr_cnt >= 2) begin
                buff_prog_full = 1'b1;
                pf_left = v.pf_cycles;
            end else if (pf_left > 0) begin
                pf_left--;
                if (pf_left == 0) buff_prog_full = 1'b0;
            end
        end
        buff_prog_full = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("cmpt_count", 128'(cmpt_cnt), 128'd1);
        chk("wr_count", 128'(wr_cnt), 128'(v.exp_wr));
        chk("req_count", 128'(req_cnt), 128'(v.exp_req));
        chk("en_cycles", 128'(en_cycles), 128'(v.exp_req * (v.rdy_dly + 1)));
        chk("en_while_full", 128'(en_full), 128'd0);
        for (int r = 0; r < v.exp_req && r < 3; r++)
            chk("araddr", 128'(addr_log[r]), 128'(v.exp_a[r]));
        chk("crc", 128'(cap_crc32), 128'(crc_model(4 * int'(v.len), zero_data)));
        cap_crc_en = 1'b0;
        @(negedge clk); #1;
        chk("crc_clear", 128'(cap_crc32), 128'hFFFFFFFF);
        cap_crc_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        vec_t post;
        vecs[0] = '{32'h1000_0000, 16'd1, 2, 0,  2, 1, {32'd0, 32'd0, 32'h1000_0000}};
        vecs[1] = '{32'h2000_0000, 16'd3, 1, 10, 6, 3, {32'h2000_0040, 32'h2000_0020, 32'h2000_0000}};
        vecs[2] = '{32'h3000_0000, 16'd0, 0, 0,  0, 0, {32'd0, 32'd0, 32'd0}};
        vecs[3] = '{32'hFFFF_FFE0, 16'd2, 0, 0,  4, 2, {32'd0, 32'h0000_0000, 32'hFFFF_FFE0}};
        post    = '{32'h4000_0000, 16'd1, 0, 0,  2, 1, {32'd0, 32'd0, 32'h4000_0000}};

        rst = 1'b0; racp_en = 1'b0; cap_addr = '0; cap_len = '0; cap_crc_en = 1'b1;
        buff_prog_full = 1'b0; m_rdy = 1'b0; m_vld = 1'b0; m_dat = '0;
        resp_on = 1'b1; zero_data = 1'b0; rdy_dly = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmpt", 128'(racp_cmpt), 128'd0);
        chk("rst_crc", 128'(cap_crc32), 128'hFFFFFFFF);
        chk("rst_din", buff_din, 128'd0);
        chk("rst_wr", 128'(buff_wr), 128'd0);
        chk("rst_en", 128'(acp0_rx_en), 128'd0);
        chk("rst_araddr", 128'(acp0_rx_araddr), 128'd0);
        chk("rst_arid", 128'(acp0_rx_arid), 128'd0);
        rst = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Zero-length: completion two cycles after the request cycle.
        cap_len = '0; racp_en = 1'b1;
        @(negedge clk); #1;
        racp_en = 1'b0;
        chk("len0_cyc1", 128'(racp_cmpt), 128'd0);
        @(negedge clk); #1;
        chk("len0_cyc2", 128'(racp_cmpt), 128'd1);
        @(negedge clk); #1;
        chk("len0_cyc3", 128'(racp_cmpt), 128'd0);
        chk("len0_en", 128'(req_cnt), 128'd0);
        chk("len0_wr", 128'(wr_cnt), 128'd0);

        // All-zero beats through the CRC.
        zero_data = 1'b1;
        run_vec(post);
        zero_data = 1'b0;

        // Reset after the second beat of a burst.
        resp_on = 1'b0;
        cap_addr = 32'h5000_0000; cap_len = 16'd1; racp_en = 1'b1;
        @(negedge clk); #1;
        racp_en = 1'b0;
        cyc = 0;
        while (!acp0_rx_en && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("rseq_en", 128'(acp0_rx_en), 128'd1);
        m_rdy = 1'b1;
        @(negedge clk); #1;
        m_rdy = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            m_dat = 64'(k); m_vld = 1'b1;
            @(negedge clk); #1;
        end
        m_vld = 1'b0;
        chk("rseq_wr_before", 128'(buff_wr), 128'd1);
        rst = 1'b0;
        #1;
        chk("rseq_cmpt", 128'(racp_cmpt), 128'd0);
        chk("rseq_crc", 128'(cap_crc32), 128'hFFFFFFFF);
        chk("rseq_din", buff_din, 128'd0);
        chk("rseq_wr", 128'(buff_wr), 128'd0);
        chk("rseq_en0", 128'(acp0_rx_en), 128'd0);
        chk("rseq_araddr", 128'(acp0_rx_araddr), 128'd0);
        m_dat = 64'd3; m_vld = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        m_dat = 64'd4;
        repeat (3) @(negedge clk);
        #1;
        m_vld = 1'b0;
        chk("idle_vld_crc", 128'(cap_crc32), 128'hFFFFFFFF);
        chk("idle_vld_wr", 128'(wr_cnt), 128'd1);
        chk("idle_vld_en", 128'(acp0_rx_en), 128'd0);
        resp_on = 1'b1;
        run_vec(post);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
